csa_tree_pipe: RTL and testbench



---
 rtl/csa_tree_pipe.sv | 191 +++++++++++++++++++
 tb/tb_csa_tree_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_tree_pipe.sv
// csa_tree_pipe
// Pipelined carry-save reduction tree. N_OPS operands are extended to
// OUT_WIDTH (sign- or zero-extension, chosen per operand set by signed_i)
// and reduced level by level with 3:2 compressors until one sum row and
// one carry row remain. The caller adds sum_o + carry_o in a final CPA.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   in_valid_i   operand set valid
//   in_ready_o   operand set accepted this cycle when valid
//   operands_i   [N_OPS-1:0][IN_WIDTH-1:0] operands
//   signed_i     1: two's complement operands, 0: unsigned
//   tag_i        user tag travelling with the operand set
//   out_valid_o  result valid
//   out_ready_i  consumer accepts result
//   sum_o        sum row
//   carry_o      carry row, already weighted (shifted left by one)
//   tag_o        tag of the presented result
//
// PIPE_MASK bit k registers the outputs of tree level k. Each registered
// level is an elastic stage (valid bit + data + tag); ready flows
// combinationally backwards through the registered stages so a full
// pipeline drains without bubbles.
module csa_tree_pipe #(
  parameter int         N_OPS     = 8,
  parameter int         IN_WIDTH  = 16,
  parameter int         OUT_WIDTH = IN_WIDTH + $clog2(N_OPS),
  parameter int         TAG_WIDTH = 4,
  parameter logic [7:0] PIPE_MASK = 8'hFF
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [N_OPS-1:0][IN_WIDTH-1:0]     operands_i,
  input  logic                               signed_i,
  input  logic [TAG_WIDTH-1:0]               tag_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [OUT_WIDTH-1:0]               sum_o,
  output logic [OUT_WIDTH-1:0]               carry_o,
  output logic [TAG_WIDTH-1:0]               tag_o
);

  // Rows entering level lvl: each level maps n rows to 2*floor(n/3) + n%3.
  function automatic int rows_at(input int lvl);
    int n;
    n = N_OPS;
    for (int i = 0; i < lvl; i++) begin
      n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

  // Number of levels needed to get down to two rows.
  function automatic int calc_levels();
    int n;
    int l;
    n = N_OPS;
    l = 0;
    for (int i = 0; i < 32; i++) begin
      if (n > 2) begin
        n = 2 * (n / 3) + (n % 3);
        l = l + 1;
      end
    end
    return l;
  endfunction

  localparam int             L        = calc_levels();
  localparam int             EXT      = OUT_WIDTH - IN_WIDTH;
  localparam logic [L-1:0]   REG_MASK = PIPE_MASK[L-1:0];

  typedef logic [N_OPS-1:0][OUT_WIDTH-1:0] rows_t;

  // One reduction level: full groups of three rows become (sum, carry<<1),
  // leftover rows are passed through behind them. Unused rows are zero.
  function automatic rows_t compress(input rows_t d, input int n);
    rows_t                r;
    int                   g;
    logic [OUT_WIDTH-1:0] a;
    logic [OUT_WIDTH-1:0] b;
    logic [OUT_WIDTH-1:0] c;
    r = '0;
    g = n / 3;
    for (int j = 0; j < N_OPS / 3; j++) begin
      if (j < g) begin
        a            = d[3*j];
        b            = d[3*j+1];
        c            = d[3*j+2];
        r[2*j]       = a ^ b ^ c;
        // Carry MSB falls off the top: arithmetic is modulo 2^OUT_WIDTH.
        r[2*j+1]     = ((a & b) | (a & c) | (b & c)) << 1;
      end
    end
    for (int m = 0; m < 2; m++) begin
      if (m < n % 3) begin
        r[2*g+m] = d[3*g+m];
      end
    end
    return r;
  endfunction

  // Operand extension
  rows_t w_ext;

  genvar gi;
  generate
    for (gi = 0; gi < N_OPS; gi++) begin : g_ext
      assign w_ext[gi] = signed_i ? {{EXT{operands_i[gi][IN_WIDTH-1]}}, operands_i[gi]}
                                  : {{EXT{1'b0}}, operands_i[gi]};
    end
  endgenerate

  // Per-level state (registers only change for levels selected in REG_MASK)
  logic [L-1:0]          r_valid;
  rows_t                 r_data [0:L-1];
  logic [TAG_WIDTH-1:0]  r_tag  [0:L-1];

  // Per-level combinational signals
  rows_t                 w_comb [0:L-1];  // compressor output of level k
  logic [L-1:0]          w_vin;           // valid arriving at level k
  logic [TAG_WIDTH-1:0]  w_tin  [0:L-1];  // tag arriving at level k
  logic [L-1:0]          w_rdy;           // ready into level k

  // Forward path: data/valid/tag ripple through combinational levels and
  // restart from the register of every registered level.
  always_comb begin
    rows_t                cur_rows;
    logic                 cur_v;
    logic [TAG_WIDTH-1:0] cur_t;
    cur_rows = w_ext;
    cur_v    = in_valid_i;
    cur_t    = tag_i;
    w_vin    = '0;
    w_comb   = '{default: '0};
    w_tin    = '{default: '0};
    for (int k = 0; k < L; k++) begin
      w_vin[k]  = cur_v;
      w_tin[k]  = cur_t;
      w_comb[k] = compress(cur_rows, rows_at(k));
      if (REG_MASK[k]) begin
        cur_rows = r_data[k];
        cur_v    = r_valid[k];
        cur_t    = r_tag[k];
      end else begin
        cur_rows = w_comb[k];
      end
    end
    out_valid_o = cur_v;
    sum_o       = cur_rows[0];
    carry_o     = cur_rows[1];
    tag_o       = cur_t;
  end

  // Backward ready path: depends only on stage occupancy and out_ready_i,
  // never on any incoming valid.
  always_comb begin
    logic rdy;
    rdy   = out_ready_i;
    w_rdy = '0;
    for (int k = L - 1; k >= 0; k--) begin
      if (REG_MASK[k]) begin
        rdy = ~r_valid[k] | rdy;
      end
      w_rdy[k] = rdy;
    end
    in_ready_o = rdy;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      r_data  <= '{default: '0};
      r_tag   <= '{default: '0};
    end else begin
      for (int k = 0; k < L; k++) begin
        if (REG_MASK[k] && w_rdy[k]) begin
          // Ready means the stage is empty or draining this cycle.
          r_valid[k] <= w_vin[k];
          if (w_vin[k]) begin
            r_data[k] <= w_comb[k];
            r_tag[k]  <= w_tin[k];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_csa_tree_pipe.sv
module tb_csa_tree_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  // Default configuration: N_OPS=8, IN_WIDTH=16, OUT_WIDTH=19, latency 4
  logic              d_in_valid, d_in_ready, d_signed, d_out_valid, d_out_ready;
  logic [7:0][15:0]  d_ops;
  logic [3:0]        d_tag, d_tag_o;
  logic [18:0]       d_sum, d_carry;

  // Combinational configuration: N_OPS=3, IN_WIDTH=8, OUT_WIDTH=10
  logic              c_in_valid, c_in_ready, c_signed, c_out_valid, c_out_ready;
  logic [2:0][7:0]   c_ops;
  logic [3:0]        c_tag, c_tag_o;
  logic [9:0]        c_sum, c_carry;

  // Sparse configuration: levels 0 and 2 registered, latency 2
  logic              s_in_valid, s_in_ready, s_signed, s_out_valid, s_out_ready;
  logic [7:0][15:0]  s_ops;
  logic [3:0]        s_tag, s_tag_o;
  logic [18:0]       s_sum, s_carry;

  csa_tree_pipe u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(d_in_valid), .in_ready_o(d_in_ready),
    .operands_i(d_ops), .signed_i(d_signed), .tag_i(d_tag),
    .out_valid_o(d_out_valid), .out_ready_i(d_out_ready),
    .sum_o(d_sum), .carry_o(d_carry), .tag_o(d_tag_o)
  );

  csa_tree_pipe #(.N_OPS(3), .IN_WIDTH(8), .PIPE_MASK(8'h00)) u_comb (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(c_in_valid), .in_ready_o(c_in_ready),
    .operands_i(c_ops), .signed_i(c_signed), .tag_i(c_tag),
    .out_valid_o(c_out_valid), .out_ready_i(c_out_ready),
    .sum_o(c_sum), .carry_o(c_carry), .tag_o(c_tag_o)
  );

  csa_tree_pipe #(.PIPE_MASK(8'h05)) u_sparse (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .operands_i(s_ops), .signed_i(s_signed), .tag_i(s_tag),
    .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
    .sum_o(s_sum), .carry_o(s_carry), .tag_o(s_tag_o)
  );

  // Reference model: integer value of an operand under the chosen extension
  function automatic longint ext_val(input longint raw, input int w, input bit sg);
    if (sg && raw[w-1]) return raw - (longint'(1) << w);
    return raw;
  endfunction

  function automatic logic [18:0] ref_def(input logic [7:0][15:0] ops, input logic sg);
    longint acc;
    acc = 0;
    for (int i = 0; i < 8; i++) acc += ext_val(longint'(ops[i]), 16, sg);
    return acc[18:0];
  endfunction

  function automatic logic [9:0] ref_comb(input logic [2:0][7:0] ops, input logic sg);
    longint acc;
    acc = 0;
    for (int i = 0; i < 3; i++) acc += ext_val(longint'(ops[i]), 8, sg);
    return acc[9:0];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Push one set into the default DUT with out_ready high and check the
  // result appears exactly 4 cycles later. Entered and left at a negedge.
  task automatic run_default(input string name, input logic [7:0][15:0] ops,
                             input logic sg, input logic [3:0] tag,
                             input logic [18:0] exp);
    logic [18:0] tot;
    d_ops = ops; d_signed = sg; d_tag = tag; d_in_valid = 1'b1; d_out_ready = 1'b1;
    #1 check({name, "_in_ready"}, 64'(d_in_ready), 64'd1);
    tick();
    d_in_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      #1 check({name, "_early_valid"}, 64'(d_out_valid), 64'd0);
      tick();
    end
    #1;
    tot = d_sum + d_carry;
    check({name, "_valid"}, 64'(d_out_valid), 64'd1);
    check({name, "_tag"},   64'(d_tag_o),     64'(tag));
    check({name, "_total"}, 64'(tot),         64'(exp));
    $display("txn %s tag=%0d total=%05h", name, d_tag_o, tot);
    tick();
  endtask

  logic [3:0]  tq[$];
  logic [18:0] sq[$];

  initial begin
    logic [7:0][15:0] ops;
    logic [18:0]      tot, prev_sum, prev_carry;
    logic [3:0]       prev_tag;
    logic [9:0]       ctot;
    logic             prev_stall, acc, pop;
    int               sent, got, inflight;

    rst_n = 1'b0;
    d_in_valid = 0; d_ops = '0; d_signed = 0; d_tag = '0; d_out_ready = 0;
    c_in_valid = 0; c_ops = '0; c_signed = 0; c_tag = '0; c_out_ready = 0;
    s_in_valid = 0; s_ops = '0; s_signed = 0; s_tag = '0; s_out_ready = 0;
    repeat (2) @(negedge clk);

    // Reset state
    #1;
    check("rst_out_valid", 64'(d_out_valid), 64'd0);
    check("rst_sum",       64'(d_sum),       64'd0);
    check("rst_carry",     64'(d_carry),     64'd0);
    check("rst_tag",       64'(d_tag_o),     64'd0);
    check("rst_in_ready",  64'(d_in_ready),  64'd1);
    check("rst_sparse_valid", 64'(s_out_valid), 64'd0);
    rst_n = 1'b1;
    tick();

    // Unsigned full scale and signed/unsigned extension
    for (int i = 0; i < 8; i++) ops[i] = 16'hFFFF;
    run_default("fullscale", ops, 1'b0, 4'd3, 19'h7FFF8);
    ops = '0;
    ops[0] = 16'h8000;
    run_default("ext_signed",   ops, 1'b1, 4'd1, 19'h78000);
    run_default("ext_unsigned", ops, 1'b0, 4'd2, 19'h08000);

    // Back-pressure: 10 random sets, tags 0..9, random out_ready
    sent = 0; got = 0; inflight = 0; prev_stall = 0;
    prev_sum = '0; prev_carry = '0; prev_tag = '0;
    for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
      if (!d_in_valid && sent < 10) begin
        for (int i = 0; i < 8; i++) d_ops[i] = 16'($urandom);
        d_signed   = 1'($urandom);
        d_tag      = 4'(sent);
        d_in_valid = 1'b1;
      end
      d_out_ready = (cyc < 6) ? 1'b0 : 1'($urandom);
      #1;
      if (prev_stall) begin
        check("bp_stall_valid", 64'(d_out_valid), 64'd1);
        check("bp_stall_sum",   64'(d_sum),       64'(prev_sum));
        check("bp_stall_carry", 64'(d_carry),     64'(prev_carry));
        check("bp_stall_tag",   64'(d_tag_o),     64'(prev_tag));
      end
      check("bp_in_ready", 64'(d_in_ready), 64'(!(inflight == 4 && !d_out_ready)));
      acc = d_in_valid & d_in_ready;
      pop = d_out_valid & d_out_ready;
      if (pop) begin
        if (tq.size() == 0) begin
          check("bp_spurious_result", 64'(d_out_valid), 64'd0);
        end else begin
          tot = d_sum + d_carry;
          check("bp_tag",   64'(d_tag_o), 64'(tq.pop_front()));
          check("bp_total", 64'(tot),     64'(sq.pop_front()));
          $display("txn bp tag=%0d total=%05h", d_tag_o, tot);
        end
        got++;
      end
      if (acc) begin
        tq.push_back(d_tag);
        sq.push_back(ref_def(d_ops, d_signed));
        sent++;
      end
      inflight = inflight + int'(acc) - int'(pop);
      prev_stall = d_out_valid & ~d_out_ready;
      prev_sum = d_sum; prev_carry = d_carry; prev_tag = d_tag_o;
      tick();
      if (acc) d_in_valid = 1'b0;
    end
    check("bp_all_received", 64'(got), 64'd10);
    d_in_valid = 1'b0;
    d_out_ready = 1'b1;
    tick();

    // Reset mid-operation: three sets in flight, the oldest at the output
    d_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 8; j++) d_ops[j] = 16'($urandom);
      d_tag = 4'(10 + i);
      d_in_valid = 1'b1;
      tick();
    end
    d_in_valid = 1'b0;
    tick();
    #1 check("mid_pre_valid", 64'(d_out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",    64'(d_out_valid), 64'd0);
    check("mid_rst_sum",      64'(d_sum),       64'd0);
    check("mid_rst_carry",    64'(d_carry),     64'd0);
    check("mid_rst_tag",      64'(d_tag_o),     64'd0);
    check("mid_rst_in_ready", 64'(d_in_ready),  64'd1);
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) ops[j] = 16'($urandom);
    run_default("post_reset", ops, 1'b1, 4'd7, ref_def(ops, 1'b1));

    // Fully combinational configuration
    c_ops[0] = 8'h01; c_ops[1] = 8'h02; c_ops[2] = 8'h03;
    c_signed = 1'b0; c_tag = 4'd5; c_in_valid = 1'b1; c_out_ready = 1'b0;
    #1;
    ctot = c_sum + c_carry;
    check("comb_valid",    64'(c_out_valid), 64'd1);
    check("comb_in_ready_lo", 64'(c_in_ready), 64'd0);
    check("comb_total",    64'(ctot),        64'h006);
    check("comb_tag",      64'(c_tag_o),     64'd5);
    c_out_ready = 1'b1;
    #1 check("comb_in_ready_hi", 64'(c_in_ready), 64'd1);
    c_in_valid = 1'b0;
    #1 check("comb_valid_lo", 64'(c_out_valid), 64'd0);
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 3; i++) c_ops[i] = 8'($urandom);
      c_signed = 1'($urandom);
      c_in_valid = 1'b1;
      #1;
      ctot = c_sum + c_carry;
      check("comb_rand_total", 64'(ctot), 64'(ref_comb(c_ops, c_signed)));
      $display("txn comb signed=%0d total=%03h", c_signed, ctot);
    end
    c_in_valid = 1'b0;
    tick();

    // Sparse pipeline: 100 back-to-back sets, latency 2, one result per cycle
    tq.delete();
    sq.delete();
    s_out_ready = 1'b1;
    for (int c = 0; c < 104; c++) begin
      if (c < 100) begin
        for (int i = 0; i < 8; i++) s_ops[i] = 16'($urandom);
        s_signed = 1'($urandom);
        s_tag = 4'(c);
        s_in_valid = 1'b1;
      end else begin
        s_in_valid = 1'b0;
      end
      #1;
      if (c < 100) begin
        check("sp_in_ready", 64'(s_in_ready), 64'd1);
        tq.push_back(s_tag);
        sq.push_back(ref_def(s_ops, s_signed));
      end
      check("sp_out_valid", 64'(s_out_valid), 64'(c >= 2 && c < 102));
      if (s_out_valid && tq.size() != 0) begin
        tot = s_sum + s_carry;
        check("sp_tag",   64'(s_tag_o), 64'(tq.pop_front()));
        check("sp_total", 64'(tot),     64'(sq.pop_front()));
        $display("txn sparse tag=%0d total=%05h", s_tag_o, tot);
      end
      tick();
    end
    check("sp_queue_drained", 64'(tq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
